// File: rtl/buf_reader_if.sv
// Read-sequencer bundle: start/len request, RAM read port, output stream and status.
// master is the sequencer side, slave is the requester/RAM/consumer side.
interface buf_reader_if #(
  parameter int W  = 4,
  parameter int DW = 16
);
  logic          start;
  logic [W:0]    len;
  logic          rd_en;
  logic [W-1:0]  rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, len, rd_data, m_ready,
    output rd_en, rd_addr, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, len, rd_data, m_ready,
    input  rd_en, rd_addr, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/buf_reader.sv
// Sweeps RAM addresses 0..len-1 and streams the words out; 3 cycles start->first m_valid.
// Backpressure: at most 2 words buffered or in flight, rd_en throttles combinationally on m_ready.
module buf_reader #(
  parameter int W  = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  buf_reader_if.master  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [W:0]    len_q, issued, delivered;
  logic [W-1:0]  addr;
  logic          inflight;
  logic [DW-1:0] mem [2];
  logic          wptr, rptr;
  logic [1:0]    occ;
  logic [2:0]    pending;
  logic          pop, issue, accept, last_pop, head_last, done_q;

  assign accept    = (state == IDLE) && bus.start && (bus.len != '0);
  assign pop       = (occ != 2'd0) && bus.m_ready;
  assign head_last = (delivered == len_q - (W+1)'(1));
  assign last_pop  = pop && head_last;
  // Words already committed to the FIFO slots once this cycle's pop leaves.
  assign pending   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && (issued < len_q) && (pending < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      addr      <= '0;
      inflight  <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      occ       <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      done_q   <= last_pop || ((state == IDLE) && bus.start && (bus.len == '0));
      if (accept) begin
        len_q     <= bus.len;
        issued    <= '0;
        addr      <= '0;
        delivered <= '0;
      end else begin
        if (issue) begin
          issued <= issued + (W+1)'(1);
          addr   <= addr + W'(1);
        end
        if (pop)
          delivered <= delivered + (W+1)'(1);
      end
      if (inflight) begin
        mem[wptr] <= bus.rd_data;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_pop) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en   = issue;
    bus.rd_addr = addr;
    bus.m_valid = (occ != 2'd0);
    bus.m_data  = mem[rptr];
    bus.m_last  = (occ != 2'd0) && head_last;
    bus.busy    = (state == RUN);
    bus.done    = done_q;
  end
endmodule

// File: doc/buf_reader.md
# buf_reader

Read-side sequencer for the sample buffers filled by the write address counter. On `start`, it sweeps read addresses 0..len-1 into a synchronous single-port RAM with one-cycle read latency. It returns the words on a valid/ready stream, absorbing downstream backpressure without losing or duplicating data. It is the consumer end of every sequentially written buffer in the design.

## Interface
- `W`, 4: RAM address width; buffer holds up to 2^W words.
- `DW`, 16: data word width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request to begin a readback; ignored while `busy`=1.
- `len`  in  W+1  words to read, 0..2^W; sampled only in the cycle `start` is accepted.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  W  RAM read address, valid when `rd_en`=1.
- `rd_data`  in  DW  RAM output; valid the cycle after `rd_en`.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts the word when `m_valid`=1 in the same cycle.
- `m_data`  out  DW  output word.
- `m_last`  out  1  marks word index len-1; qualified by `m_valid`.
- `busy`  out  1  readback in progress.
- `done`  out  1  one-cycle pulse when a readback completes.

## Operation
- State machine states are IDLE and RUN.
- IDLE:
  - `start`=1 with `len`>0 latches `len`, clears the issue counter, the read address and the delivered counter, and moves to RUN.
  - `start`=1 with `len`=0 pulses `done` in the next cycle and stays in IDLE. It never asserts `busy`, `rd_en` or `m_valid`.
- RUN:
  - Issue rule: `rd_en` = (issued < len) AND (occ + inflight − pop < 2).
  - occ is the output FIFO occupancy (0..2). inflight is the registered `rd_en` of the previous cycle. pop is `m_valid & m_ready`.
  - The combinational path from `m__ready` to `rd_en` is intended. It sustains one word per cycle.
  - `rd_addr` increments by 1 per issue, modulo 2^W. With len=2^W it wraps to 0 after the last issue and is not used again.
  - The issued and delivered counters are W+1 bits wide.
  - The cycle after each issue, `rd_data` is written into a 2-entry FIFO. The FIFO never overflows by construction.
  - `m_data`/`m_valid` come from the FIFO head. `m_last` = (head word index == len-1).
  - `m_data`, `m_last` and `m_valid` hold stable while `m_valid`=1 and `m_ready`=0.
  - When the word with `m_last`=1 is accepted, the block returns to IDLE. `done` pulses in the next cycle, and `busy` is 0 in that same cycle.
- `start` while `busy`=1 is ignored. `len` changes during RUN have no effect.
- `start` in the same cycle as the `done` pulse is accepted, because the block is already in IDLE.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `done`=0. State is IDLE.
- `rst` has priority over everything. Mid-readback it flushes the FIFO, discards the in-flight read, and produces no `done`.
- Cycle-level sequence, with `start` accepted in cycle 0:
  - Cycle 1: `busy`=1, first `rd_en` with `rd_addr`=0.
  - Cycle 2: `rd_data` for address 0 is valid and written into the FIFO.
  - Cycle 3: `m_valid`=1 with word 0.
  - This gives 3 cycles of latency from `start` to the first `m_valid`.
- With `m_ready` held at 1, `m_valid` is continuous from cycle 3 to cycle len+2. `done` pulses at cycle len+3.
- Backpressure: at most 2 words are buffered or in flight. After `m_ready` rises again, words resume in the same cycle from the FIFO with no bubble.

## Test plan
- RAM holds addr×3. Apply `start`, `len`=5, `m_ready`=1. Required response:
  - `rd_addr` 0..4 in cycles 1..5.
  - `m_data` 0,3,6,9,12 in cycles 3..7, with `m_last` only on 12.
  - `done` at cycle 8; `busy` high in cycles 1..7.
- `len`=5 with `m_ready` low in cycles 3..6, then high. Required response:
  - `rd_en` stops after 2 issues and `m_data` holds 0 while stalled.
  - The full sequence 0,3,6,9,12 is delivered with no loss or duplicates.
- `len`=2^W=16 with `m_ready` random 50%. Required response:
  - 16 words in order, addresses 0..15.
  - `rd_addr` wraps to 0 after the last issue.
  - Exactly one `m_last` and one `done`.
- `start` with `len`=0. Required response: `done` pulses the next cycle; `busy`, `rd_en` and `m_valid` stay 0.
- `start` pulsed again mid-readback, and `start` pulsed in the `done` cycle. Required response:
  - The mid-readback `start` is ignored.
  - The `start` in the `done` cycle begins a new readback whose first `rd_en` comes one cycle later.
- `rst` asserted in cycle 4 of a `len`=8 readback. Required response:
  - All outputs match reset values the next cycle, with no `done`.
  - A subsequent `start`, `len`=3, delivers words 0,3,6 correctly.
